mem_bridge_8b: RTL
==================

// Module: mem_bridge_8b
// PURPOSE
//  Memory-side responder for the core's 16-bit load/store bus (mem_assert/mem_rdy, be0/be1).
//  Turns each 16-bit byte-enabled request into one or two 8-bit accesses on an external
//  asynchronous SRAM/ROM bus, inserting programmable wait states.
//  Returns assembled read data and pulses mem_rdy once per request.
//  Sits between the core LSU and the board memory.
// PARAMETERS
//  WAIT_STATES  1  extra strobe cycles per byte phase, 0..15 (4-bit counter)
// PORTS
//  clk          in   1   system clock; everything is on posedge
//  rst          in   1   reset, synchronous, active-high
//  mem_assert   in   1   request valid; addr/data/cmd/be are stable while high
//  mem_addr     in   16  byte address; bit 0 selects the lane for byte accesses
//  mem_data     in   16  write data; [7:0] is lane 0 (even), [15:8] is lane 1 (odd)
//  mem_cmd      in   1   0 = read, 1 = write
//  be0          in   1   lane 0 enable (even byte)
//  be1          in   1   lane 1 enable (odd byte)
//  mem_rdy      out  1   one-cycle completion pulse
//  rd_data      out  16  read result; valid while mem_rdy is high, held afterwards
//  ext_addr     out  16  external byte address
//  ext_wdata    out  8   external write data
//  ext_rdata    in   8   external read data
//  ext_ce       out  1   chip enable, active-high
//  ext_oe       out  1   output enable, active-high
//  ext_we       out  1   write strobe, active-high
// BEHAVIOUR
//  Reset: state IDLE. mem_rdy, ext_ce, ext_oe and ext_we are 0. rd_data, ext_addr and ext_wdata are 0.
//    A reset in mid-transaction aborts it immediately: no mem_rdy pulse, all strobes drop in the next cycle.
//  FSM states: IDLE, SETUP, STROBE, DONE. A lane register records the current lane (LO or HI).
//  IDLE, mem_assert=1:
//    - Latch addr, data, cmd, be0 and be1.
//    - Clear the lanes of rd_data that will be read.
//    - If be0=1, go to SETUP with lane LO. Else if be1=1, go to SETUP with lane HI.
//    - Else (no lanes enabled) go to DONE with no external activity.
//  SETUP (1 cycle):
//    - ext_ce=1. ext_addr={addr[15:1],lane}. ext_wdata is the selected data lane.
//    - ext_we=0, ext_oe=0.
//    - Load the wait counter with WAIT_STATES, then go to STROBE.
//  STROBE (WAIT_STATES+1 cycles):
//    - ext_ce=1. ext_addr and ext_wdata are unchanged from SETUP.
//    - ext_we=cmd, ext_oe=~cmd.
//    - The counter decrements each cycle. On counter==0:
//      - On a read, capture ext_rdata into the current lane of rd_data.
//      - If lane is LO and be1=1, go to SETUP with lane HI. Otherwise go to DONE.
//  DONE (1 cycle): mem_rdy=1, all ext strobes are 0, then go to IDLE.
//  mem_assert is not sampled in DONE.
//  Back-to-back requests: the initiator updates its request on the mem_rdy edge.
//    The next request is accepted in the following IDLE cycle, which gives 1 idle cycle between requests.
//  Latency (assert first seen in IDLE = cycle 0):
//    - Single lane: mem_rdy at cycle W+3.
//    - Both lanes: mem_rdy at cycle 2W+5.
//    - No lanes: mem_rdy at cycle 1.
//  Misaligned word access (odd addr, width 16): the initiator presents be0=0, be1=1.
//    The block performs a lane-HI byte access only; it does not split the access.
//  If mem_assert drops mid-transaction (protocol violation), the transaction still completes and mem_rdy still pulses.
//  ext_we and ext_oe are never both 1. Both are 0 whenever ext_ce=0 and in every SETUP cycle.
// STRUCTURE
//  mem_bus_defs.vh (shared include):
//    - FSM state encodings.
//    - LANE_LO=1'b0, LANE_HI=1'b1.
//    - CMD_READ and CMD_WRITE.
//  Sub-module ws_counter: 4-bit loadable down-counter with load, en and zero outputs.
//  All other logic stays in the top module.
// TESTING
//  Unless noted, WAIT_STATES=1.
//  1. Read of word 0x0200 (be0=be1=1), SRAM[0x200]=0x34, SRAM[0x201]=0x12
//     -> mem_rdy at cycle 7 with rd_data=0x1234; two ce bursts, each 3 cycles, at 0x0200 then 0x0201.
//  2. Write of byte 0x55 to odd address 0x0301 (be0=0, be1=1, data=0x5500)
//     -> one phase at ext_addr=0x0301 with ext_wdata=0x55 and ext_we high for 2 cycles; mem_rdy at cycle 4.
//  3. Back-to-back: read of 0x0010 (word), then write of 0xBEEF to 0x0020 presented on the mem_rdy edge
//     -> second request accepted 1 cycle after mem_rdy; SRAM[0x20]=0xEF and SRAM[0x21]=0xBE.
//  4. be0=be1=0 with mem_assert=1
//     -> mem_rdy at cycle 1; ext_ce stays 0 throughout.
//  5. rst=1 asserted during the STROBE of the HI lane
//     -> the next cycle shows all strobes 0, state IDLE and no mem_rdy pulse; a new request then completes normally.
//  6. WAIT_STATES=0 and 15, word read
//     -> mem_rdy at cycle 5 and cycle 35 respectively; ext_oe and ext_we are never high together.

Source files
------------

// File: rtl/mem_bridge_8b_pkg.sv
// rtl/mem_bridge_8b_pkg.sv - shared types and constants for the 16-to-8 bit memory bridge
package mem_bridge_8b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic LANE_LO   = 1'b0;
  localparam logic LANE_HI   = 1'b1;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem_bridge_8b_if.sv
// rtl/mem_bridge_8b_if.sv - core-side 16-bit load/store request bus
interface mem_bridge_8b_if;
  logic        mem_assert;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_cmd;
  logic        be0;
  logic        be1;
  logic        mem_rdy;
  logic [15:0] rd_data;

  modport master (
    output mem_assert, mem_addr, mem_data, mem_cmd, be0, be1,
    input  mem_rdy, rd_data
  );

  modport slave (
    input  mem_assert, mem_addr, mem_data, mem_cmd, be0, be1,
    output mem_rdy, rd_data
  );
endinterface

// File: rtl/mem_bridge_8b_ws_counter.sv
// rtl/mem_bridge_8b_ws_counter.sv - 4-bit loadable wait-state down-counter
module ws_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/mem_bridge_8b.sv
// rtl/mem_bridge_8b.sv - splits byte-enabled 16-bit requests into 8-bit async SRAM/ROM accesses
module mem_bridge_8b
  import mem_bridge_8b_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_bridge_8b_if.slave  bus,
  output logic [15:0]     ext_addr,
  output logic [7:0]      ext_wdata,
  input  logic [7:0]      ext_rdata,
  output logic            ext_ce,
  output logic            ext_oe,
  output logic            ext_we
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic        lane_q, lane_d;
  logic [14:0] word_addr_q, word_addr_d;
  logic [15:0] data_q, data_d;
  logic        cmd_q, cmd_d;
  logic        be1_q, be1_d;
  logic [15:0] rd_data_q, rd_data_d;

  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_zero;
  logic [3:0] cnt_value;

  ws_counter u_ws_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (WS_LOAD),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_addr_d = word_addr_q;
    data_d      = data_q;
    cmd_d       = cmd_q;
    be1_d       = be1_q;
    rd_data_d   = rd_data_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_assert) begin
          word_addr_d = bus.mem_addr[15:1];
          data_d      = bus.mem_data;
          cmd_d       = bus.mem_cmd;
          be1_d       = bus.be1;
          // Only lanes about to be read are cleared; the others keep their old bytes.
          if (bus.mem_cmd == CMD_READ) begin
            if (bus.be0) rd_data_d[7:0]  = 8'h00;
            if (bus.be1) rd_data_d[15:8] = 8'h00;
          end
          if (bus.be0) begin
            state_d = ST_SETUP;
            lane_d  = LANE_LO;
          end else if (bus.be1) begin
            state_d = ST_SETUP;
            lane_d  = LANE_HI;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        cnt_load = 1'b1;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          if (cmd_q == CMD_READ) begin
            if (lane_q == LANE_HI) rd_data_d[15:8] = ext_rdata;
            else                   rd_data_d[7:0]  = ext_rdata;
          end
          if ((lane_q == LANE_LO) && be1_q) begin
            state_d = ST_SETUP;
            lane_d  = LANE_HI;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= LANE_LO;
      word_addr_q <= 15'd0;
      data_q      <= 16'd0;
      cmd_q       <= CMD_READ;
      be1_q       <= 1'b0;
      rd_data_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      word_addr_q <= word_addr_d;
      data_q      <= data_d;
      cmd_q       <= cmd_d;
      be1_q       <= be1_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Strobes decode straight from the state register, so a reset clears them on the next cycle.
  assign ext_ce    = (state_q == ST_SETUP) || (state_q == ST_STROBE);
  assign ext_we    = (state_q == ST_STROBE) && (cmd_q == CMD_WRITE);
  assign ext_oe    = (state_q == ST_STROBE) && (cmd_q == CMD_READ);
  assign ext_addr  = {word_addr_q, lane_q};
  assign ext_wdata = lane_byte(data_q, lane_q);

  assign bus.mem_rdy = (state_q == ST_DONE);
  assign bus.rd_data = rd_data_q;

endmodule
